// File: rtl/io_switch_debounce.sv
// io_switch_debounce
//   Conditions two groups of raw board switches for the CPU's memory-mapped
//   input ports. Each group is synchronised into io_clk with two flops and
//   then debounced by its own small FSM. A new value is accepted only after
//   it has been seen unchanged for DB_CYCLES consecutive cycles.
//
// Ports
//   io_clk    : I/O clock, rising-edge active
//   reset     : asynchronous, active-high reset (clears every flop)
//   sw0, sw1  : raw switch groups, asynchronous to io_clk
//   in_port0/1: debounced groups, zero-extended to 32 bits (flop outputs)
//   port0/1_upd: one-cycle pulse in the cycle the matching port changes
module io_switch_debounce #(
  parameter int WIDTH     = 5,
  parameter int DB_CYCLES = 16
) (
  input  logic              io_clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  sw0,
  input  logic [WIDTH-1:0]  sw1,
  output logic [31:0]       in_port0,
  output logic [31:0]       in_port1,
  output logic              port0_upd,
  output logic              port1_upd
);

  // Counter must hold DB_CYCLES-1 without wrapping.
  localparam int CW = $clog2(DB_CYCLES) + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_e;

  logic [WIDTH-1:0] sw_raw   [2];
  logic [WIDTH-1:0] stable_s [2];
  logic             upd_s    [2];

  assign sw_raw[0] = sw0;
  assign sw_raw[1] = sw1;

  // The two channels share no state; each is a full copy of the same logic.
  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             upd_q, upd_d;
    db_state_e        state_q, state_d;

    // Two-flop synchroniser; only s2_q is used downstream.
    always_ff @(posedge io_clk or posedge reset) begin
      if (reset) begin
        s1_q <= '0;
        s2_q <= '0;
      end else begin
        s1_q <= sw_raw[g];
        s2_q <= s1_q;
      end
    end

    // Debounce state, value and strobe registers.
    always_ff @(posedge io_clk or posedge reset) begin
      if (reset) begin
        state_q  <= IDLE;
        stable_q <= '0;
        cand_q   <= '0;
        cnt_q    <= '0;
        upd_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        stable_q <= stable_d;
        cand_q   <= cand_d;
        cnt_q    <= cnt_d;
        upd_q    <= upd_d;
      end
    end

    // Next-state logic. In COUNT a return to the stable value wins over a
    // fresh change, which in turn wins over the terminal count.
    always_comb begin
      state_d  = state_q;
      stable_d = stable_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      upd_d    = 1'b0;
      case (state_q)
        IDLE: begin
          if (s2_q != stable_q) begin
            cand_d  = s2_q;
            cnt_d   = CW'(1);
            state_d = COUNT;
          end else begin
            cnt_d   = '0;
          end
        end
        COUNT: begin
          if (s2_q == stable_q) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (s2_q != cand_q) begin
            cand_d  = s2_q;
            cnt_d   = CW'(1);
          end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            stable_d = cand_q;
            upd_d    = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end

    assign stable_s[g] = stable_q;
    assign upd_s[g]    = upd_q;
  end

  // Zero-extension written so that WIDTH == 32 needs no special case.
  always_comb begin
    in_port0 = 32'h0;
    in_port1 = 32'h0;
    in_port0[WIDTH-1:0] = stable_s[0];
    in_port1[WIDTH-1:0] = stable_s[1];
  end

  assign port0_upd = upd_s[0];
  assign port1_upd = upd_s[1];

endmodule

// File: tb/tb_io_switch_debounce.sv
// Directed testbench for io_switch_debounce (WIDTH=5, DB_CYCLES=16).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// at the same point, so the next edge is "E1" after any input change.
module tb_io_switch_debounce;

  logic        io_clk;
  logic        reset;
  logic [4:0]  sw0, sw1;
  logic [31:0] in_port0, in_port1;
  logic        port0_upd, port1_upd;

  int passed = 0;
  int total  = 0;

  io_switch_debounce #(.WIDTH(5), .DB_CYCLES(16)) dut (
    .io_clk   (io_clk),
    .reset    (reset),
    .sw0      (sw0),
    .sw1      (sw1),
    .in_port0 (in_port0),
    .in_port1 (in_port1),
    .port0_upd(port0_upd),
    .port1_upd(port1_upd)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                         input logic u0, input logic u1);
    chk({tag, "_p0"},  in_port0, p0);
    chk({tag, "_p1"},  in_port1, p1);
    chk({tag, "_u0"},  {31'h0, port0_upd}, {31'h0, u0});
    chk({tag, "_u1"},  {31'h0, port1_upd}, {31'h0, u1});
  endtask

  // n edges with both ports unchanged and no strobe
  task automatic hold(input string tag, input int n, input logic [31:0] p0, input logic [31:0] p1);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_all(tag, p0, p1, 1'b0, 1'b0);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                      input logic u0, input logic u1);
    tick();
    chk_all(tag, p0, p1, u0, u1);
  endtask

  initial begin
    reset = 1'b0;
    sw0   = 5'h1F;
    sw1   = 5'h0A;
    #1 reset = 1'b1;

    // Reset held with non-zero switches
    repeat (3) tick();
    chk_all("rst", 32'h0, 32'h0, 1'b0, 1'b0);

    // Release: values appear at edge 18
    reset = 1'b0;
    hold("rel_wait", 17, 32'h0, 32'h0);
    step("rel_upd", 32'h1F, 32'h0A, 1'b1, 1'b1);
    step("rel_after", 32'h1F, 32'h0A, 1'b0, 1'b0);

    // Bring port0 to 0
    sw0 = 5'h00;
    hold("to0_wait", 17, 32'h1F, 32'h0A);
    step("to0_upd", 32'h0, 32'h0A, 1'b1, 1'b0);

    // Clean change from stable0 = 0
    sw0 = 5'h15;
    hold("clean_wait", 17, 32'h0, 32'h0A);
    step("clean_upd", 32'h15, 32'h0A, 1'b1, 1'b0);
    step("clean_after", 32'h15, 32'h0A, 1'b0, 1'b0);

    sw0 = 5'h00;
    hold("back0_wait", 17, 32'h15, 32'h0A);
    step("back0_upd", 32'h0, 32'h0A, 1'b1, 1'b0);

    // Glitch of 10 cycles must be ignored
    sw0 = 5'h04;
    hold("glitch", 10, 32'h0, 32'h0A);
    sw0 = 5'h00;
    hold("glitch_after", 30, 32'h0, 32'h0A);

    // Bring port1 to 0 before the bounce test
    sw1 = 5'h00;
    hold("p1to0_wait", 17, 32'h0, 32'h0A);
    step("p1to0_upd", 32'h0, 32'h0, 1'b0, 1'b1);

    // Bounce: toggle every 3 cycles for 30 cycles, then hold 03
    for (int k = 0; k < 5; k++) begin
      sw1 = 5'h03;
      hold("bounce_hi", 3, 32'h0, 32'h0);
      sw1 = 5'h00;
      hold("bounce_lo", 3, 32'h0, 32'h0);
    end
    sw1 = 5'h03;
    hold("bounce_wait", 17, 32'h0, 32'h0);
    step("bounce_upd", 32'h0, 32'h3, 1'b0, 1'b1);
    step("bounce_after", 32'h0, 32'h3, 1'b0, 1'b0);

    // Simultaneous multi-bit change on both groups
    sw0 = 5'h0A;
    sw1 = 5'h1C;
    hold("simul_wait", 17, 32'h0, 32'h3);
    step("simul_upd", 32'h0A, 32'h1C, 1'b1, 1'b1);
    step("simul_after", 32'h0A, 32'h1C, 1'b0, 1'b0);

    // Reset when both counters are at 8 (after the 10th edge)
    sw0 = 5'h11;
    sw1 = 5'h05;
    hold("mid_wait", 10, 32'h0A, 32'h1C);
    reset = 1'b1;
    #1;
    chk_all("mid_rst", 32'h0, 32'h0, 1'b0, 1'b0);
    step("mid_rst_held", 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    hold("mid_rel_wait", 17, 32'h0, 32'h0);
    step("mid_rel_upd", 32'h11, 32'h05, 1'b1, 1'b1);
    step("mid_rel_after", 32'h11, 32'h05, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
